// File: rtl/lcm_pkg.sv
// Shared types and constants for the layered colour mapper.
// Default widths here match the mapper's default parameters.
package lcm_pkg;

    localparam int unsigned LCM_IDX_W   = 4;
    localparam int unsigned LCM_PAL_W   = 3;
    localparam int unsigned LCM_COLOR_W = 8;
    localparam int unsigned PAL_DEPTH   = 2 ** (LCM_PAL_W + LCM_IDX_W);
    localparam int unsigned LEVEL_MAX   = (2 ** LCM_COLOR_W) - 1;

    typedef struct packed {
        logic [LCM_COLOR_W-1:0] r;
        logic [LCM_COLOR_W-1:0] g;
        logic [LCM_COLOR_W-1:0] b;
    } rgb_t;

    typedef logic [LCM_PAL_W+LCM_IDX_W-1:0] pal_addr_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_OUT,
        F_BLACK,
        F_IN
    } fade_state_e;

    typedef enum logic {
        INIT,
        RUN
    } init_state_e;

endpackage

// File: rtl/lcm_palette_ram.sv
// Palette storage: one write port, one synchronous read-first read port.
// No reset, so the array maps onto block RAM.
module lcm_palette_ram #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;

    // Read samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/layered_color_mapper.sv
// Layer priority resolve -> palette RAM lookup -> fade scale, 3-cycle pipeline.
// Optional frame-stepped fade is enabled by defining LCM_FADE_EN.
module layered_color_mapper
    import lcm_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned IDX_W      = LCM_IDX_W,
    parameter int unsigned PAL_W      = LCM_PAL_W,
    parameter int unsigned COLOR_W    = LCM_COLOR_W,
    parameter int unsigned TRANSP_IDX = 0,
    parameter int unsigned FADE_STEP  = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic                        blank_n,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS-1:0]       layer_valid,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS*PAL_W-1:0] layer_pal,
    input  logic                        pal_wr_valid,
    output logic                        pal_wr_ready,
    input  logic [PAL_W+IDX_W-1:0]      pal_wr_addr,
    input  logic [3*COLOR_W-1:0]        pal_wr_rgb,
    input  logic                        fade_start,
    output logic                        fade_busy,
    output logic                        init_done,
    output logic [COLOR_W-1:0]          VGA_R,
    output logic [COLOR_W-1:0]          VGA_G,
    output logic [COLOR_W-1:0]          VGA_B,
    output logic [9:0]                  out_DrawX,
    output logic [9:0]                  out_DrawY
);

    localparam int unsigned AW = PAL_W + IDX_W;
    localparam int unsigned DW = 3 * COLOR_W;
    localparam logic [IDX_W-1:0]   TRANSP_L = IDX_W'(TRANSP_IDX);
    localparam logic [AW-1:0]      LAST_K   = '1;

    // ---------------- init FSM ----------------
    init_state_e   init_state_q, init_state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          init_done_q, init_done_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [COLOR_W-1:0] grey;

    assign pal_wr_ready = init_done_q && !blank_n;
    assign init_done    = init_done_q;

    always_comb begin
        init_state_d = init_state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        grey         = COLOR_W'(init_cnt_q[IDX_W-1:0]) << (COLOR_W - IDX_W);
        ram_we       = pal_wr_valid && pal_wr_ready;
        ram_waddr    = pal_wr_addr;
        ram_wdata    = pal_wr_rgb;
        case (init_state_q)
            INIT: begin
                ram_we     = 1'b1;
                ram_waddr  = init_cnt_q;
                ram_wdata  = {grey, grey, grey};
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_K) begin
                    init_state_d = RUN;
                    init_done_d  = 1'b1;
                end
            end
            RUN: ;
            default: init_state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            init_state_q <= INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            init_state_q <= init_state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
        end
    end

    // ---------------- fade level ----------------
    logic [COLOR_W-1:0] level;

`ifdef LCM_FADE_EN
    localparam logic [COLOR_W-1:0] LVL_MAX = '1;
    localparam logic [COLOR_W-1:0] STEP_L  = COLOR_W'(FADE_STEP);

    fade_state_e        fade_state_q, fade_state_d;
    logic [COLOR_W-1:0] level_q, level_d;

    always_comb begin
        fade_state_d = fade_state_q;
        level_d      = level_q;
        case (fade_state_q)
            F_IDLE: if (fade_start) fade_state_d = F_OUT;
            F_OUT: if (frame_start) begin
                if (level_q <= STEP_L) begin
                    level_d      = '0;
                    fade_state_d = F_BLACK;
                end else begin
                    level_d = level_q - STEP_L;
                end
            end
            F_BLACK: if (frame_start) fade_state_d = F_IN;
            F_IN: if (frame_start) begin
                if (level_q >= LVL_MAX - STEP_L) begin
                    level_d      = LVL_MAX;
                    fade_state_d = F_IDLE;
                end else begin
                    level_d = level_q + STEP_L;
                end
            end
            default: fade_state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fade_state_q <= F_IDLE;
            level_q      <= LVL_MAX;
        end else begin
            fade_state_q <= fade_state_d;
            level_q      <= level_d;
        end
    end

    assign level     = level_q;
    assign fade_busy = (fade_state_q != F_IDLE);

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] ch,
                                                 input logic [COLOR_W-1:0] lvl);
        logic [2*COLOR_W-1:0] p;
        p = {{COLOR_W{1'b0}}, ch} * {{COLOR_W{1'b0}}, lvl};
        return p[2*COLOR_W-1:COLOR_W];
    endfunction
`else
    logic unused_fade;
    assign unused_fade = ^{fade_start, frame_start, level, FADE_STEP[0]};
    assign level       = '1;
    assign fade_busy   = 1'b0;
`endif

    // ---------------- stage 1: layer resolve ----------------
    logic [PAL_W-1:0] sel_pal_q, sel_pal_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
    logic             win_found;
    logic             blank1_q, blank2_q;
    logic [9:0]       x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;

    always_comb begin
        win_found = 1'b0;
        sel_pal_d = '0;
        sel_idx_d = TRANSP_L;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!win_found && layer_valid[i] &&
                layer_idx[i*IDX_W +: IDX_W] != TRANSP_L) begin
                win_found = 1'b1;
                sel_pal_d = layer_pal[i*PAL_W +: PAL_W];
                sel_idx_d = layer_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    // ---------------- stage 2: palette read ----------------
    logic [DW-1:0] rd_data;

    lcm_palette_ram #(
        .AW(AW),
        .DW(DW)
    ) u_pal_ram (
        .clk    (Clk),
        .wr_en  (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(ram_wdata),
        .rd_addr({sel_pal_q, sel_idx_q}),
        .rd_data(rd_data)
    );

    // ---------------- stage 3: fade + blank ----------------
    logic [COLOR_W-1:0] ch_r, ch_g, ch_b;
    logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;
    logic [COLOR_W-1:0] vga_r_d, vga_g_d, vga_b_d;

    always_comb begin
`ifdef LCM_FADE_EN
        ch_r = scale(rd_data[DW-1 -: COLOR_W], level);
        ch_g = scale(rd_data[2*COLOR_W-1 -: COLOR_W], level);
        ch_b = scale(rd_data[COLOR_W-1:0], level);
`else
        ch_r = rd_data[DW-1 -: COLOR_W];
        ch_g = rd_data[2*COLOR_W-1 -: COLOR_W];
        ch_b = rd_data[COLOR_W-1:0];
`endif
        vga_r_d = blank2_q ? ch_r : '0;
        vga_g_d = blank2_q ? ch_g : '0;
        vga_b_d = blank2_q ? ch_b : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_pal_q <= '0;
            sel_idx_q <= '0;
            blank1_q  <= 1'b0;
            blank2_q  <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            x3_q      <= '0;
            y3_q      <= '0;
            vga_r_q   <= '0;
            vga_g_q   <= '0;
            vga_b_q   <= '0;
        end else begin
            sel_pal_q <= sel_pal_d;
            sel_idx_q <= sel_idx_d;
            blank1_q  <= blank_n;
            blank2_q  <= blank1_q;
            x1_q      <= DrawX;
            y1_q      <= DrawY;
            x2_q      <= x1_q;
            y2_q      <= y1_q;
            x3_q      <= x2_q;
            y3_q      <= y2_q;
            vga_r_q   <= vga_r_d;
            vga_g_q   <= vga_g_d;
            vga_b_q   <= vga_b_d;
        end
    end

    assign VGA_R     = vga_r_q;
    assign VGA_G     = vga_g_q;
    assign VGA_B     = vga_b_q;
    assign out_DrawX = x3_q;
    assign out_DrawY = y3_q;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Directed self-checking bench for layered_color_mapper (default parameters).
// Fade checks are compiled in only when LCM_FADE_EN is defined.
module tb_layered_color_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_n, frame_start;
    logic [2:0]  layer_valid;
    logic [11:0] layer_idx;
    logic [8:0]  layer_pal;
    logic        pal_wr_valid;
    logic        pal_wr_ready;
    logic [6:0]  pal_wr_addr;
    logic [23:0] pal_wr_rgb;
    logic        fade_start, fade_busy, init_done;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [9:0]  out_DrawX, out_DrawY;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 Clk = ~Clk;

    layered_color_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank_n(blank_n), .frame_start(frame_start),
        .layer_valid(layer_valid), .layer_idx(layer_idx), .layer_pal(layer_pal),
        .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready),
        .pal_wr_addr(pal_wr_addr), .pal_wr_rgb(pal_wr_rgb),
        .fade_start(fade_start), .fade_busy(fade_busy), .init_done(init_done),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_DrawX(out_DrawX), .out_DrawY(out_DrawY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output scaling seen at full brightness
    function automatic logic [7:0] scl(input logic [7:0] c);
`ifdef LCM_FADE_EN
        logic [15:0] p;
        p = {8'd0, c} * 16'd255;
        return p[15:8];
`else
        return c;
`endif
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [23:0] c);
        return {scl(c[23:16]), scl(c[15:8]), scl(c[7:0])};
    endfunction

    task automatic set_layers(input logic [2:0] v, input logic [11:0] idx, input logic [8:0] pal);
        layer_valid = v;
        layer_idx   = idx;
        layer_pal   = pal;
    endtask

    // Apply a held pixel at a negedge, then wait out the 3-cycle latency
    task automatic show(input logic bn, input logic [2:0] v, input logic [11:0] idx,
                        input logic [8:0] pal);
        @(negedge Clk);
        blank_n = bn;
        set_layers(v, idx, pal);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 300) begin
            @(posedge Clk);
            n++;
            #1;
        end
    endtask

    // Fresh colour and coordinates every cycle; output must trail by exactly 3 edges
    task automatic stream(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            blank_n = 1'b1;
            DrawX   = 10'(100 + i);
            DrawY   = 10'(200 + i);
            set_layers(3'b001, {8'h00, 4'(i + 1)}, 9'd0);
            @(posedge Clk);
            #1;
            if (i >= 2) begin
                check_eq({tag, "_x"}, {22'd0, out_DrawX}, 32'(100 + i - 2));
                check_eq({tag, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B},
                         {8'd0, exp_rgb({3{8'(4'(i - 1)) << 4}})});
            end
        end
    endtask

    task automatic host_write(input logic [6:0] a, input logic [23:0] d);
        @(negedge Clk);
        blank_n      = 1'b0;
        pal_wr_valid = 1'b1;
        pal_wr_addr  = a;
        pal_wr_rgb   = d;
        @(posedge Clk);
        @(negedge Clk);
        pal_wr_valid = 1'b0;
    endtask

`ifdef LCM_FADE_EN
    task automatic pulse_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask
`endif

    initial begin
        Reset_n = 1'b0; DrawX = '0; DrawY = '0; blank_n = 1'b0; frame_start = 1'b0;
        layer_valid = '0; layer_idx = '0; layer_pal = '0;
        pal_wr_valid = 1'b0; pal_wr_addr = '0; pal_wr_rgb = '0; fade_start = 1'b0;

        // Reset state
        #12;
        check_eq("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check_eq("rst_init_done", {31'd0, init_done}, 32'd0);
        check_eq("rst_ready", {31'd0, pal_wr_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, fade_busy}, 32'd0);

        @(negedge Clk);
        Reset_n = 1'b1;
        wait_init(cyc);
        check_eq("init_cycles", 32'(cyc), 32'd128);

        // Grey ramp entry {3,5}
        show(1'b1, 3'b001, 12'h005, 9'o003);
        check_eq("grey_3_5", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h505050)});

        // Priority and transparency
        show(1'b1, 3'b111, {4'd2, 4'd7, 4'd0}, {3'd1, 3'd6, 3'd4});
        check_eq("prio_l1", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h707070)});
        show(1'b1, 3'b111, {4'd2, 4'd9, 4'd3}, 9'd0);
        check_eq("prio_l0", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h303030)});
        show(1'b1, 3'b110, {4'd2, 4'd9, 4'd4}, 9'd0);
        check_eq("prio_l0_invalid", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h909090)});

        stream("lat");

        // Write during active video waits on ready
        @(negedge Clk);
        blank_n = 1'b1;
        set_layers(3'b001, 12'h009, 9'o002);
        pal_wr_valid = 1'b1;
        pal_wr_addr  = {3'd2, 4'd9};
        pal_wr_rgb   = 24'hFF0000;
        #1;
        check_eq("ready_active", {31'd0, pal_wr_ready}, 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        check_eq("write_held", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h909090)});
        @(negedge Clk);
        blank_n = 1'b0;
        #1;
        check_eq("ready_blank", {31'd0, pal_wr_ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        pal_wr_valid = 1'b0;
        host_write(7'h00, 24'h123456);

        show(1'b1, 3'b001, 12'h009, 9'o002);
        check_eq("red_2_9", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'hFF0000)});
        show(1'b1, 3'b111, 12'h000, 9'o777);
        check_eq("backdrop_transp", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h123456)});
        show(1'b1, 3'b000, 12'h9A5, 9'o123);
        check_eq("backdrop_novalid", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h123456)});
        show(1'b0, 3'b001, 12'h009, 9'o002);
        check_eq("blank_black", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);

`ifdef LCM_FADE_EN
        show(1'b1, 3'b001, 12'h005, 9'o003);
        @(negedge Clk);
        fade_start = 1'b1;
        @(negedge Clk);
        fade_start = 1'b0;
        #1;
        check_eq("fade_busy_on", {31'd0, fade_busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            pulse_frame();
            if (i == 7) begin
                @(negedge Clk);
                fade_start = 1'b1;
                @(negedge Clk);
                fade_start = 1'b0;
            end
        end
        repeat (4) @(posedge Clk);
        #1;
        check_eq("fade_black", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        pulse_frame();
        for (int i = 0; i < 15; i++) pulse_frame();
        #1;
        check_eq("fade_busy_in", {31'd0, fade_busy}, 32'd1);
        pulse_frame();
        #1;
        check_eq("fade_busy_off", {31'd0, fade_busy}, 32'd0);
        repeat (4) @(posedge Clk);
        #1;
        check_eq("fade_restored", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h505050)});
`endif

        // Mid-frame reset
        @(negedge Clk);
        blank_n = 1'b1;
        set_layers(3'b001, 12'h009, 9'o002);
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("mid_rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check_eq("mid_rst_x", {22'd0, out_DrawX}, 32'd0);
        check_eq("mid_rst_init", {31'd0, init_done}, 32'd0);
        @(negedge Clk);
        blank_n = 1'b0;
        Reset_n = 1'b1;
        wait_init(cyc);
        check_eq("reinit_cycles", 32'(cyc), 32'd128);
        show(1'b1, 3'b001, 12'h009, 9'o002);
        check_eq("reinit_grey_2_9", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb(24'h909090)});
        stream("lat_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
